rf_port_sched: RTL and testbench
================================

# rf_port_sched

Round-robin port scheduler that shares the single-access 32x32 register file (two read ports, one write port, registered read outputs) between NREQ requesters. It accepts read or write transactions over a valid/ready request channel and drives the register-file control and address pins. Read data returns on a shared response channel tagged with the requester ID. It sits between the execute/load units and the register file, and is the only block that drives register-file pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- ID_W, $clog2(NREQ), requester ID width
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_we  input  NREQ  1 = write, 0 = read
- req_addr_a  input  NREQ*5  read address A, or write address when req_we=1
- req_addr_b  input  NREQ*5  read address B (ignored for writes)
- req_wdata  input  NREQ*32  write data
- req_ready  output  NREQ  one-hot acceptance pulse
- rsp_valid  output  1  read response valid
- rsp_id  output  ID_W  requester that issued the read
- rsp_data_a / rsp_data_b  output  32  read data for addresses A and B
- rsp_ready  input  1  response consumer ready
- rf_enable, rf_read, rf_write  output  1  register-file controls
- rf_o1_addr, rf_o2_addr, rf_in_addr  output  5  register-file addresses
- rf_in  output  32  register-file write data
- rf_o1, rf_o2  input  32  register-file read outputs (registered inside the register file)

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is high, pick the winner by round robin, starting the search at ptr.
  - Latch the winner's we, addresses, wdata and ID into internal registers.
  - Go to ISSUE.
- ISSUE (exactly one cycle):
  - req_ready[winner]=1 for this cycle only.
  - rf_read=~we and rf_write=we.
  - Address and data outputs come from the latched values.
  - ptr becomes (winner+1) mod NREQ.
  - For a write, go to IDLE. For a read, go to RESP.
- RESP:
  - rsp_valid=1, rsp_id=latched ID.
  - rsp_data_a=rf_o1 and rsp_data_b=rf_o2.
  - Stay in RESP until rsp_ready=1, then go to IDLE.
  - No new request is accepted while in RESP.
- rf_enable=1 whenever reset is deasserted.
- rf_read and rf_write are 0 outside ISSUE, and are never both 1.
- Requesters must hold req_valid and the payload stable until they see req_ready. The payload is sampled only on the IDLE->ISSUE transition.
- Requesters that are not granted are not starved: the ptr rotation gives each requester at most NREQ-1 intervening grants.
- Reset values:
  - State is IDLE and ptr is 0.
  - All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_data_a, rsp_data_b, rf_enable, rf_read, rf_write, all rf addresses, and rf_in.

## Timing
- Read: req_valid in cycle 0 (IDLE) → ISSUE in cycle 1 (req_ready and rf_read high) → the register file captures at the end of cycle 1 → rsp_valid in cycle 2.
- Write: req_valid in cycle 0 → ISSUE in cycle 1 → the register file is written at the end of cycle 1 → IDLE in cycle 2.
- Peak throughput is one write every 2 cycles, or one read every 3 cycles.
- A read issued in the cycle immediately after a write to the same address returns the new data, because the write completes at the end of the earlier ISSUE cycle.
- Reset asserted mid-transaction:
  - State immediately becomes IDLE and all outputs go to 0.
  - Any in-flight transaction is dropped. No response is given and the requester re-requests.
  - A write that has not reached the clock edge ending ISSUE is not performed.
- req_valid dropped before req_ready violates the protocol. The scheduler has no required behaviour except that the transaction latched on entry to ISSUE still completes.

## Configuration
- RF_ZERO_REG_EN defined:
  - Register 0 reads as 0: rsp_data_a is forced to 0 when latched addr_a==0, and likewise for rsp_data_b.
  - Writes to address 0 are accepted (req_ready pulses), but rf_write stays 0.
- RF_ZERO_REG_EN undefined: register 0 behaves like any other register.

## Structure
- Package rf_sched_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32.
  - The state enum (IDLE, ISSUE, RESP).
- Sub-module rr_pick is combinational: inputs req vector and ptr; outputs one-hot grant, winner index and any.
  - The FSM and ptr register live in rf_port_sched.

## Test plan
- Reset: hold reset=0 with traffic on req_valid → all outputs 0 and no req_ready. Release reset → rf_enable=1 on the next edge.
- Write then read: requester 1 writes 32'd111111 to address 30, then reads A=30, B=10 → rsp_data_a=111111, rsp_data_b=0, rsp_id=1. rsp_valid arrives exactly 2 cycles after the read's req_valid.
- Fairness: all 4 requesters keep req_valid high, all issuing writes → grant order is 0,1,2,3,0; each req_ready is a single-cycle pulse 2 cycles apart.
- Backpressure: read response with rsp_ready held at 0 for 5 cycles → rsp_valid and the data stay stable, no req_ready is issued, and IDLE is re-entered the cycle after rsp_ready=1.
- Reset mid-read: assert reset during RESP → rsp_valid drops immediately. After release, the same read re-issued returns the correct data.
- RF_ZERO_REG_EN: write 32'd9999999 to address 0, then read A=0 → rf_write stays 0 and rsp_data_a=0. With the macro undefined, the same read returns 9999999.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_sched_pkg
//
// Shared definitions for the register-file port scheduler:
//   - register-file geometry (address width, data width, depth)
//   - scheduler FSM state encoding
//   - wrap_idx helper used for round-robin index arithmetic
//
// No ports; imported by rr_pick and rf_port_sched.
// ---------------------------------------------------------------------------
package rf_sched_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Wraps an index that is known to be below 2*n back into 0..n-1.
  // A subtract is enough here, so no divider is built for the modulo.
  function automatic int wrap_idx(input int value, input int n);
    return (value >= n) ? (value - n) : value;
  endfunction

endpackage

// File: rtl/rf_port_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Searches the request vector starting at
// index ptr and wrapping around; the first set bit found wins.
//
// Parameters:
//   NREQ   number of requesters
//   ID_W   width of a requester index
// Ports:
//   req     in   NREQ   request vector
//   ptr     in   ID_W   index the search starts from (highest priority)
//   grant   out  NREQ   one-hot grant (all zero when nothing requests)
//   winner  out  ID_W   index of the granted requester
//   any     out  1      at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
  import rf_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  int idx;

  // Walk the requesters in priority order ptr, ptr+1, ... and stop at the
  // first one that is asking; "any" doubles as the found flag.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = wrap_idx(int'(ptr) + i, NREQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_port_sched.sv
// ---------------------------------------------------------------------------
// rf_port_sched
//
// Round-robin scheduler sharing a 32x32 register file (two registered read
// ports, one write port) between NREQ requesters. One transaction at a time:
//   IDLE  -> pick a winner, latch its payload
//   ISSUE -> one cycle, pulse req_ready, drive register-file pins
//   RESP  -> reads only, hold the response until rsp_ready
//
// Optional feature macro: RF_ZERO_REG_EN
//   defined   : register 0 reads as zero and writes to it are suppressed
//               (the request is still acknowledged)
//   undefined : register 0 is an ordinary register
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   ID_W  requester id width
// Ports:
//   clk          in   1          system clock, rising edge
//   reset        in   1          asynchronous reset, active low
//   req_valid    in   NREQ       per-requester request valid
//   req_we       in   NREQ       1 = write, 0 = read
//   req_addr_a   in   NREQ*5     read address A / write address
//   req_addr_b   in   NREQ*5     read address B
//   req_wdata    in   NREQ*32    write data
//   req_ready    out  NREQ       one-hot acceptance pulse
//   rsp_valid    out  1          read response valid
//   rsp_id       out  ID_W       requester that issued the read
//   rsp_data_a   out  32         read data for address A
//   rsp_data_b   out  32         read data for address B
//   rsp_ready    in   1          response consumer ready
//   rf_enable    out  1          register-file enable
//   rf_read      out  1          register-file read strobe
//   rf_write     out  1          register-file write strobe
//   rf_o1_addr   out  5          read port 1 address
//   rf_o2_addr   out  5          read port 2 address
//   rf_in_addr   out  5          write port address
//   rf_in        out  32         write data
//   rf_o1        in   32         read port 1 data (registered in the RF)
//   rf_o2        in   32         read port 2 data (registered in the RF)
// ---------------------------------------------------------------------------
module rf_port_sched
  import rf_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ*RF_ADDR_W-1:0]   req_addr_a,
  input  logic [NREQ*RF_ADDR_W-1:0]   req_addr_b,
  input  logic [NREQ*RF_DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [RF_DATA_W-1:0]        rsp_data_a,
  output logic [RF_DATA_W-1:0]        rsp_data_b,
  input  logic                        rsp_ready,
  output logic                        rf_enable,
  output logic                        rf_read,
  output logic                        rf_write,
  output logic [RF_ADDR_W-1:0]        rf_o1_addr,
  output logic [RF_ADDR_W-1:0]        rf_o2_addr,
  output logic [RF_ADDR_W-1:0]        rf_in_addr,
  output logic [RF_DATA_W-1:0]        rf_in,
  input  logic [RF_DATA_W-1:0]        rf_o1,
  input  logic [RF_DATA_W-1:0]        rf_o2
);

  state_t                 state_q;
  state_t                 state_d;
  logic [ID_W-1:0]        ptr_q;
  logic                   enable_q;

  logic                   we_q;
  logic [RF_ADDR_W-1:0]   addr_a_q;
  logic [RF_ADDR_W-1:0]   addr_b_q;
  logic [RF_DATA_W-1:0]   wdata_q;
  logic [ID_W-1:0]        id_q;
  logic [NREQ-1:0]        grant_q;

  logic [NREQ-1:0]        pick_grant;
  logic [ID_W-1:0]        pick_winner;
  logic                   pick_any;

  logic                   in_issue;
  logic                   in_resp;
  logic                   write_allowed;
  logic                   zero_a;
  logic                   zero_b;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Next-state logic. ISSUE always lasts a single cycle; only reads
  // continue into RESP, which waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and payload registers. The payload is captured only on
  // the IDLE->ISSUE transition so a requester misbehaving afterwards cannot
  // corrupt the transaction already in flight. The pointer advances past the
  // winner during ISSUE, which is what bounds the wait of every requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      enable_q <= 1'b0;
      we_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      wdata_q  <= '0;
      id_q     <= '0;
      grant_q  <= '0;
    end else begin
      enable_q <= 1'b1;
      state_q  <= state_d;
      if (state_q == IDLE && pick_any) begin
        we_q     <= req_we[pick_winner];
        addr_a_q <= req_addr_a[pick_winner*RF_ADDR_W +: RF_ADDR_W];
        addr_b_q <= req_addr_b[pick_winner*RF_ADDR_W +: RF_ADDR_W];
        wdata_q  <= req_wdata[pick_winner*RF_DATA_W +: RF_DATA_W];
        id_q     <= pick_winner;
        grant_q  <= pick_grant;
      end
      if (state_q == ISSUE) begin
        ptr_q <= ID_W'(wrap_idx(int'(id_q) + 1, NREQ));
      end
    end
  end

  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

`ifdef RF_ZERO_REG_EN
  // Register 0 is hard-wired to zero: never write it, and mask whatever the
  // register file returns for it.
  assign write_allowed = (addr_a_q != '0);
  assign zero_a        = (addr_a_q == '0);
  assign zero_b        = (addr_b_q == '0);
`else
  assign write_allowed = 1'b1;
  assign zero_a        = 1'b0;
  assign zero_b        = 1'b0;
`endif

  // Register-file pins are only non-zero during ISSUE so the bus is quiet
  // whenever no access is taking place.
  always_comb begin
    req_ready  = in_issue ? grant_q : '0;
    rf_enable  = enable_q;
    rf_read    = in_issue & ~we_q;
    rf_write   = in_issue & we_q & write_allowed;
    rf_o1_addr = (in_issue & ~we_q) ? addr_a_q : '0;
    rf_o2_addr = (in_issue & ~we_q) ? addr_b_q : '0;
    rf_in_addr = (in_issue & we_q)  ? addr_a_q : '0;
    rf_in      = (in_issue & we_q)  ? wdata_q  : '0;
  end

  // Response channel. The register file holds its read outputs until the
  // next read, so they can be passed straight through while in RESP.
  always_comb begin
    rsp_valid  = in_resp;
    rsp_id     = in_resp ? id_q : '0;
    rsp_data_a = (in_resp && !zero_a) ? rf_o1 : '0;
    rsp_data_b = (in_resp && !zero_b) ? rf_o2 : '0;
  end

endmodule

// File: tb/tb_rf_port_sched.sv
// ---------------------------------------------------------------------------
// tb_rf_port_sched
//
// Directed self-checking bench for rf_port_sched with NREQ=4. Contains a
// behavioural 32x32 register file with registered read outputs. Honours
// RF_ZERO_REG_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_rf_port_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_we;
  logic [NREQ*5-1:0]   req_addr_a;
  logic [NREQ*5-1:0]   req_addr_b;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_data_a;
  logic [31:0]         rsp_data_b;
  logic                rsp_ready;
  logic                rf_enable;
  logic                rf_read;
  logic                rf_write;
  logic [4:0]          rf_o1_addr;
  logic [4:0]          rf_o2_addr;
  logic [4:0]          rf_in_addr;
  logic [31:0]         rf_in;
  logic [31:0]         rf_o1;
  logic [31:0]         rf_o2;

  logic [31:0]         rf_mem [32];

  int errors = 0;
  int checks = 0;

  rf_port_sched #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rsp_ready  (rsp_ready),
    .rf_enable  (rf_enable),
    .rf_read    (rf_read),
    .rf_write   (rf_write),
    .rf_o1_addr (rf_o1_addr),
    .rf_o2_addr (rf_o2_addr),
    .rf_in_addr (rf_in_addr),
    .rf_in      (rf_in),
    .rf_o1      (rf_o1),
    .rf_o2      (rf_o2)
  );

  always #5 clk = ~clk;

  // Register file model: writes and read captures both happen at the edge
  // that ends the ISSUE cycle; read outputs hold until the next read.
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rf_o1 = '0;
    rf_o2 = '0;
  end

  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_in_addr] <= rf_in;
    if (rf_read) begin
      rf_o1 <= rf_mem[rf_o1_addr];
      rf_o2 <= rf_mem[rf_o2_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_payload(input int id, input logic we, input logic [4:0] a,
                             input logic [4:0] b, input logic [31:0] d);
    req_we[id]           = we;
    req_addr_a[id*5 +: 5] = a;
    req_addr_b[id*5 +: 5] = b;
    req_wdata[id*32 +: 32] = d;
  endtask

  // Single write from one requester; starts and ends in IDLE.
  task automatic do_write(input int id, input logic [4:0] a, input logic [31:0] d,
                          input logic exp_we);
    set_payload(id, 1'b1, a, 5'd0, d);
    req_valid = '0;
    req_valid[id] = 1'b1;
    tick();
    check_output("wr_ready", 32'(req_ready), 32'(1 << id));
    check_output("wr_rf_write", 32'(rf_write), 32'(exp_we));
    check_output("wr_rf_read", 32'(rf_read), 32'd0);
    check_output("wr_addr", 32'(rf_in_addr), 32'(a));
    check_output("wr_data", rf_in, d);
    req_valid = '0;
    tick();
  endtask

  // Single read with rsp_ready high; starts and ends in IDLE.
  task automatic do_read(input int id, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
    set_payload(id, 1'b0, a, b, 32'd0);
    req_valid = '0;
    req_valid[id] = 1'b1;
    tick();
    check_output("rd_ready", 32'(req_ready), 32'(1 << id));
    check_output("rd_rf_read", 32'(rf_read), 32'd1);
    check_output("rd_rf_write", 32'(rf_write), 32'd0);
    check_output("rd_addr_a", 32'(rf_o1_addr), 32'(a));
    check_output("rd_rsp_early", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    tick();
    check_output("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check_output("rd_rsp_id", 32'(rsp_id), 32'(id));
    check_output("rd_data_a", rsp_data_a, exp_a);
    check_output("rd_data_b", rsp_data_b, exp_b);
    tick();
    check_output("rd_rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    rsp_ready  = 1'b1;
    req_valid  = '1;
    req_we     = '1;
    req_addr_a = '1;
    req_addr_b = '1;
    req_wdata  = '1;

    // Reset held with traffic present: everything stays quiet.
    tick();
    tick();
    check_output("rst_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rf_enable", 32'(rf_enable), 32'd0);
    check_output("rst_rf_rw", 32'({rf_read, rf_write}), 32'd0);
    check_output("rst_addrs", 32'({rf_o1_addr, rf_o2_addr, rf_in_addr}), 32'd0);
    check_output("rst_rf_in", rf_in, 32'd0);
    check_output("rst_rsp_data", rsp_data_a | rsp_data_b | 32'(rsp_id), 32'd0);

    req_valid = '0;
    reset = 1'b1;
    check_output("rel_enable_before", 32'(rf_enable), 32'd0);
    tick();
    check_output("rel_enable_after", 32'(rf_enable), 32'd1);

    // Fairness: all four write continuously, pointer starts at 0.
    for (int i = 0; i < NREQ; i++) set_payload(i, 1'b1, 5'(20 + i), 5'd0, 32'(100 + i));
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_output("fair_grant", 32'(req_ready), 32'(1 << (g % 4)));
      check_output("fair_addr", 32'(rf_in_addr), 32'(20 + (g % 4)));
      check_output("fair_data", rf_in, 32'(100 + (g % 4)));
      if (g == 4) req_valid = '0;
      tick();
      check_output("fair_gap", 32'(req_ready), 32'd0);
    end

    // Write then immediate read of the same address.
    do_write(1, 5'd30, 32'd111111, 1'b1);
    do_read(1, 5'd30, 5'd10, 32'd111111, 32'd0);

    // Backpressure with a competing write waiting.
    rsp_ready = 1'b0;
    set_payload(2, 1'b0, 5'd20, 5'd30, 32'd0);
    req_valid = 4'b0100;
    tick();
    check_output("bp_ready", 32'(req_ready), 32'b0100);
    set_payload(3, 1'b1, 5'd5, 5'd0, 32'd55);
    req_valid = 4'b1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output("bp_valid", 32'(rsp_valid), 32'd1);
      check_output("bp_data_a", rsp_data_a, 32'd100);
      check_output("bp_data_b", rsp_data_b, 32'd111111);
      check_output("bp_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    check_output("bp_still_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    check_output("bp_idle_valid", 32'(rsp_valid), 32'd0);
    check_output("bp_idle_ready", 32'(req_ready), 32'd0);
    tick();
    check_output("bp_next_grant", 32'(req_ready), 32'b1000);
    check_output("bp_next_write", 32'(rf_write), 32'd1);
    req_valid = '0;
    tick();

    // Reset during RESP, then replay the read.
    rsp_ready = 1'b0;
    set_payload(0, 1'b0, 5'd30, 5'd20, 32'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check_output("mr_resp", 32'(rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_output("mr_drop_valid", 32'(rsp_valid), 32'd0);
    check_output("mr_drop_data", rsp_data_a, 32'd0);
    check_output("mr_drop_enable", 32'(rf_enable), 32'd0);
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    tick();
    do_read(0, 5'd30, 5'd20, 32'd111111, 32'd100);

    // Register 0 behaviour.
`ifdef RF_ZERO_REG_EN
    do_write(2, 5'd0, 32'd9999999, 1'b0);
    do_read(2, 5'd0, 5'd30, 32'd0, 32'd111111);
`else
    do_write(2, 5'd0, 32'd9999999, 1'b1);
    do_read(2, 5'd0, 5'd30, 32'd9999999, 32'd111111);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
